conv_out_buffer: RTL and testbench

CONV_OUT_BUFFER -- requirements
Module: conv_out_buffer

---
 rtl/conv_out_buffer_if.sv | 22 ++
 rtl/conv_out_buffer.sv | 110 +++++++++++
 tb/tb_conv_out_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/conv_out_buffer_if.sv
// Stream bundle between conv_8_4 (y side), conv_out_buffer and the consumer (z side).
// Ports: s_data_in_y/s_valid_y/s_ready_y (18-bit signed upstream), m_data_out_z/m_valid_z/
//        m_ready_z/m_last_z (16-bit signed downstream). slave = buffer view, master = environment view.
interface conv_out_buffer_if;
  logic signed [17:0] s_data_in_y;
  logic               s_valid_y;
  logic               s_ready_y;
  logic signed [15:0] m_data_out_z;
  logic               m_valid_z;
  logic               m_ready_z;
  logic               m_last_z;

  modport slave (
    input  s_data_in_y, s_valid_y, m_ready_z,
    output s_ready_y, m_data_out_z, m_valid_z, m_last_z
  );

  modport master (
    output s_data_in_y, s_valid_y, m_ready_z,
    input  s_ready_y, m_data_out_z, m_valid_z, m_last_z
  );
endinterface

// File: rtl/conv_out_buffer.sv
// Purpose: saturating FWFT FIFO for conv_8_4 results, tagging the last y of each convolution.
// Latency: word pushed into an empty buffer at edge N is at the head after that edge (cycle N+1).
// Backpressure: s_ready_y = (count < DEPTH) from registered count; no push when full, even with a pop.
// Ports: clk, reset (async active-low), bus (conv_out_buffer_if.slave), count (occupancy),
//        sat_flag (sticky, any clamped push since reset).
// Option: define CONV_OUT_RELU_EN to force negative inputs to 0 before saturation.
module conv_out_buffer #(
  parameter int DEPTH            = 8,
  parameter int LOGDEPTH         = 3,
  parameter int OUTPUTS_PER_CONV = 5
) (
  input  logic                clk,
  input  logic                reset,
  conv_out_buffer_if.slave    bus,
  output logic [LOGDEPTH:0]   count,
  output logic                sat_flag
);

  localparam int PCW = (OUTPUTS_PER_CONV > 1) ? $clog2(OUTPUTS_PER_CONV) : 1;

  // Entry layout: {last, data[15:0]}. Storage is not reset; outputs are gated by valid instead.
  logic [16:0]         mem_q [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOGDEPTH:0]   count_q, count_d;
  logic [PCW-1:0]      push_cnt_q, push_cnt_d;
  logic                sat_q, sat_d;

  logic                push, pop;
  logic                last_in;
  logic                clamped;
  logic signed [15:0]  sat_dat;
  logic [16:0]         head;

  assign bus.s_ready_y = (count_q < (LOGDEPTH+1)'(DEPTH));
  assign bus.m_valid_z = (count_q != '0);
  assign push          = bus.s_valid_y & bus.s_ready_y;
  assign pop           = bus.m_valid_z & bus.m_ready_z;
  assign last_in       = (push_cnt_q == PCW'(OUTPUTS_PER_CONV - 1));

  // An 18-bit value fits in 16 bits exactly when bits [17:15] agree.
  always_comb begin
    sat_dat = bus.s_data_in_y[15:0];
    clamped = 1'b0;
`ifdef CONV_OUT_RELU_EN
    if (bus.s_data_in_y[17]) begin
      sat_dat = '0;
    end else if (bus.s_data_in_y[16:15] != 2'b00) begin
      sat_dat = 16'sh7fff;
      clamped = 1'b1;
    end
`else
    if (!bus.s_data_in_y[17] && (bus.s_data_in_y[16:15] != 2'b00)) begin
      sat_dat = 16'sh7fff;
      clamped = 1'b1;
    end else if (bus.s_data_in_y[17] && (bus.s_data_in_y[16:15] != 2'b11)) begin
      sat_dat = 16'sh8000;
      clamped = 1'b1;
    end
`endif
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_cnt_d = push_cnt_q;
    sat_d      = sat_q;
    if (push) begin
      wr_ptr_d   = (wr_ptr_q == LOGDEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      push_cnt_d = last_in ? '0 : push_cnt_q + 1'b1;
      if (clamped) sat_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LOGDEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      push_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      push_cnt_q <= push_cnt_d;
      sat_q      <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_in, sat_dat};
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.m_data_out_z = bus.m_valid_z ? head[15:0] : '0;
  assign bus.m_last_z     = bus.m_valid_z & head[16];
  assign count            = count_q;
  assign sat_flag         = sat_q;

endmodule

// File: tb/tb_conv_out_buffer.sv
module tb_conv_out_buffer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count;
  logic       sat_flag;
  int checks = 0;
  int errors = 0;

  conv_out_buffer_if bus();

  conv_out_buffer #(.DEPTH(8), .LOGDEPTH(3), .OUTPUTS_PER_CONV(5)) dut (
    .clk(clk), .reset(reset), .bus(bus), .count(count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Leaves the bench at a negedge with reset released and inputs idle.
  task automatic do_reset();
    bus.s_valid_y = 1'b0;
    bus.s_data_in_y = '0;
    bus.m_ready_z = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (bus.m_valid_z !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b want 0", bus.m_valid_z); end
    checks++; if (bus.s_ready_y !== 1'b1) begin errors++; $display("FAIL reset_sready got %b want 1", bus.s_ready_y); end
    checks++; if (bus.m_last_z !== 1'b0) begin errors++; $display("FAIL reset_mlast got %b want 0", bus.m_last_z); end
    checks++; if (bus.m_data_out_z !== 16'sd0) begin errors++; $display("FAIL reset_mdata got %0d want 0", bus.m_data_out_z); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_flag); end
  endtask

  task automatic test_passthrough();
    do_reset();
    bus.m_ready_z = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = 18'(i);
      @(posedge clk); @(negedge clk);
      checks++; if (bus.m_valid_z !== 1'b1 || bus.m_data_out_z !== 16'(i))
        begin errors++; $display("FAIL pass_data[%0d] got v=%b d=%0d want v=1 d=%0d", i, bus.m_valid_z, bus.m_data_out_z, i); end
      checks++; if (bus.m_last_z !== (i == 5))
        begin errors++; $display("FAIL pass_last[%0d] got %b want %b", i, bus.m_last_z, (i == 5)); end
    end
    bus.s_valid_y = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (count !== 4'd0 || bus.m_valid_z !== 1'b0)
      begin errors++; $display("FAIL pass_empty got count=%0d v=%b want 0 0", count, bus.m_valid_z); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.s_ready_y !== (i < 8))
        begin errors++; $display("FAIL full_sready[%0d] got %b want %b", i, bus.s_ready_y, (i < 8)); end
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = 18'(10 + i);
      @(posedge clk); @(negedge clk);
    end
    bus.s_valid_y = 1'b0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", count); end
    checks++; if (bus.m_data_out_z !== 16'sd10) begin errors++; $display("FAIL full_head_hold got %0d want 10", bus.m_data_out_z); end
    bus.m_ready_z = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.m_data_out_z !== 16'(10 + k) || bus.m_last_z !== (k == 4))
        begin errors++; $display("FAIL full_drain[%0d] got d=%0d l=%b want d=%0d l=%b", k, bus.m_data_out_z, bus.m_last_z, 10 + k, (k == 4)); end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drained got %0d want 0", count); end
  endtask

  task automatic test_saturation();
    logic signed [17:0] vin [4];
    logic signed [15:0] vexp [4];
    logic               sexp [4];
    vin[0] = 18'sd32767;  vexp[0] = 16'sd32767;  sexp[0] = 1'b0;
    vin[1] = -18'sd32768; sexp[1] = 1'b0;
    vin[2] = 18'sd40000;  vexp[2] = 16'sd32767;  sexp[2] = 1'b1;
    vin[3] = -18'sd40000; sexp[3] = 1'b1;
`ifdef CONV_OUT_RELU_EN
    vexp[1] = 16'sd0;     vexp[3] = 16'sd0;
`else
    vexp[1] = -16'sd32768; vexp[3] = -16'sd32768;
`endif
    do_reset();
    bus.m_ready_z = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = vin[i];
      @(posedge clk); @(negedge clk);
      checks++; if (bus.m_data_out_z !== vexp[i])
        begin errors++; $display("FAIL sat_data[%0d] got %0d want %0d", i, bus.m_data_out_z, vexp[i]); end
      checks++; if (sat_flag !== sexp[i])
        begin errors++; $display("FAIL sat_flag[%0d] got %b want %b", i, sat_flag, sexp[i]); end
    end
    bus.s_valid_y = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = 18'(100 + i);
      @(posedge clk); @(negedge clk);
    end
    bus.m_ready_z = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.s_data_in_y = 18'(103 + k);
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 3", k, count); end
      checks++; if (bus.m_data_out_z !== 16'(100 + k) || bus.m_last_z !== (k % 5 == 4))
        begin errors++; $display("FAIL b2b_head[%0d] got d=%0d l=%b want d=%0d l=%b", k, bus.m_data_out_z, bus.m_last_z, 100 + k, (k % 5 == 4)); end
      @(posedge clk); @(negedge clk);
    end
    bus.s_valid_y = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.m_data_out_z !== 16'(110 + k) || bus.m_last_z !== 1'b0)
        begin errors++; $display("FAIL b2b_drain[%0d] got d=%0d l=%b want d=%0d l=0", k, bus.m_data_out_z, bus.m_last_z, 110 + k); end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = (i == 0) ? 18'sd40000 : 18'(200 + i);
      @(posedge clk); @(negedge clk);
    end
    bus.s_valid_y = 1'b0;
    checks++; if (count !== 4'd4 || sat_flag !== 1'b1)
      begin errors++; $display("FAIL arst_pre got count=%0d sat=%b want 4 1", count, sat_flag); end
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || bus.m_valid_z !== 1'b0 || bus.s_ready_y !== 1'b1)
      begin errors++; $display("FAIL arst_now got count=%0d v=%b r=%b want 0 0 1", count, bus.m_valid_z, bus.s_ready_y); end
    checks++; if (bus.m_data_out_z !== 16'sd0 || bus.m_last_z !== 1'b0 || sat_flag !== 1'b0)
      begin errors++; $display("FAIL arst_out got d=%0d l=%b sat=%b want 0 0 0", bus.m_data_out_z, bus.m_last_z, sat_flag); end
    @(negedge clk);
    reset = 1'b1;
    bus.m_ready_z = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = 18'(300 + i);
      @(posedge clk); @(negedge clk);
      checks++; if (bus.m_data_out_z !== 16'(300 + i) || bus.m_last_z !== (i == 5))
        begin errors++; $display("FAIL arst_post[%0d] got d=%0d l=%b want d=%0d l=%b", i, bus.m_data_out_z, bus.m_last_z, 300 + i, (i == 5)); end
    end
    bus.s_valid_y = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_negative();
    logic signed [15:0] want;
`ifdef CONV_OUT_RELU_EN
    want = 16'sd0;
`else
    want = -16'sd7;
`endif
    do_reset();
    bus.m_ready_z = 1'b1;
    bus.s_valid_y = 1'b1;
    bus.s_data_in_y = -18'sd7;
    @(posedge clk); @(negedge clk);
    bus.s_valid_y = 1'b0;
    checks++; if (bus.m_valid_z !== 1'b1 || bus.m_data_out_z !== want)
      begin errors++; $display("FAIL neg_data got v=%b d=%0d want v=1 d=%0d", bus.m_valid_z, bus.m_data_out_z, want); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL neg_sat got %b want 0", sat_flag); end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    bus.s_valid_y = 1'b0;
    bus.s_data_in_y = '0;
    bus.m_ready_z = 1'b0;
    test_reset();
    test_passthrough();
    test_full();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    test_negative();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
